median3x3_seq: RTL
==================

Name: median3x3_seq

Overview:
- Computes the median of one 3x3 disparity window per transaction by time-sharing a single `sort_3` comparator network over 7 sequential passes.
- Sits in the SGM post-processing chain between the window generator (line buffers) and the output formatter.
- Trades throughput (one median per 8+ cycles) for area: one 3-input sorter instead of the 7 a fully parallel network would need.

Parameters:
- WIDTH, 16, bit width of one pixel/disparity; passed to the shared `sort_3` instance.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  window on in_win is valid.
- in_ready  output  1  block can accept a window this cycle.
- in_win  input  9*WIDTH  pixel k = row r, col c, with k = 3r+c, at bits [k*WIDTH +: WIDTH].
- out_valid  output  1  out_med holds a result.
- out_ready  input  1  downstream accepts the result.
- out_med  output  WIDTH  median of the window.
- busy  output  1  high in any state other than S_IDLE.

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset `rst`.
- Reset values: state = S_IDLE, out_valid = 0, out_med = 0, all internal registers 0, in_ready = 1 (combinational from S_IDLE).
- Reset mid-operation: the window in flight and any pending result are discarded; the next cycle is S_IDLE.
- Accept: in_valid & in_ready at a rising edge. All 9 pixels are registered into win_r and the state moves to S_C0.
- in_ready = (state == S_IDLE) | (state == S_OUT & out_ready). This allows back-to-back operation: release and accept in the same cycle.
- Pass states: the one `sort_3` instance has its inputs driven by a mux selected by state. Its outputs are captured at the end of each state.
  - S_C0: sort column 0, pixels 0, 3, 6. Store hi0 = max, md0 = med, lo0 = min.
  - S_C1: sort column 1, pixels 1, 4, 7. Store hi1, md1, lo1.
  - S_C2: sort column 2, pixels 2, 5, 8. Store hi2, md2, lo2.
  - S_R0: sort (lo0, lo1, lo2). Store A = max.
  - S_R1: sort (md0, md1, md2). Store B = med.
  - S_R2: sort (hi0, hi1, hi2). Store C = min.
  - S_FIN: sort (A, B, C). Load out_med = med and set out_valid = 1. Next state is S_OUT.
- S_OUT: out_valid stays 1 and out_med stays stable until out_ready.
  - out_ready & in_valid: accept the new window, go to S_C0, out_valid = 0 next cycle.
  - out_ready & !in_valid: go to S_IDLE, out_valid = 0.
  - !out_ready: hold.
- Latency: from accept edge to out_valid high is 8 clock edges.
- Throughput: one window per 8 cycles when out_ready is held high.
- Ties: duplicate values give the correct median. `sort_3` uses strict > compares, so the ordering among equal values does not affect the result.
- Arithmetic: unsigned comparison only, no width growth.
- in_win is ignored outside the accept cycle. Changes on in_win during passes have no effect.
- busy = (state != S_IDLE), and includes S_OUT.

Optional Feature:
- Macro: MEDIAN3X3_BYPASS_EN.
- When defined:
  - Adds input port `bypass` (1 bit), sampled only on accept.
  - If bypass = 1 on accept, out_med = pixel 4 (centre) and the state goes directly to S_OUT. out_valid rises 1 edge after accept.
  - If bypass = 0 on accept, behaviour is unchanged from the base block.
- When undefined: the port does not exist and the block always filters.

Test Plan:
- Reset then single window 9,1,5,3,7,2,8,4,6 (pixels 0..8), out_ready=1. Expect out_valid rises 8 edges after accept, out_med=5, then S_IDLE, in_ready=1.
- Window all 16'hFFFF, then window {0,0,0,0,1,1,1,1,1}. Expect medians 16'hFFFF and 1. Checks ties and full-scale values.
- Backpressure: out_ready=0 for 5 cycles after out_valid. Expect out_med stable, in_ready=0, no new accept. Then out_ready=1 with in_valid=1 gives accept in the same cycle and out_valid=0 next.
- Streaming: 4 windows back-to-back, out_ready=1. Expect a result every 8 cycles, in order, each matching a software median reference.
- Reset asserted in S_R1. Expect next cycle state S_IDLE, out_valid=0, out_med=0. The next window yields its correct median with no residue from the aborted one.
- With MEDIAN3X3_BYPASS_EN, bypass=1, window centre=42. Expect out_valid 1 edge after accept and out_med=42. With bypass=0 the same window gives the normal median.

Source files
------------

// File: rtl/median3x3_seq.sv
// 3x3 window median by time-sharing one sort_3 network over 7 passes (column, row-extreme, final).
// Optional centre-pixel bypass when MEDIAN3X3_BYPASS_EN is defined.
module median3x3_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9*WIDTH-1:0]   in_win,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_med,
`ifdef MEDIAN3X3_BYPASS_EN
    input  logic                 bypass,
`endif
    output logic                 busy
);

    localparam int unsigned NPIX = 9;
    localparam int unsigned NCOL = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_C0, S_C1, S_C2, S_R0, S_R1, S_R2, S_FIN, S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] win_r [NPIX];
    logic [WIDTH-1:0] hi_r  [NCOL];
    logic [WIDTH-1:0] md_r  [NCOL];
    logic [WIDTH-1:0] lo_r  [NCOL];
    logic [WIDTH-1:0] a_r, b_r, c_r;

    logic [WIDTH-1:0] srt_a, srt_b, srt_c;
    logic [WIDTH-1:0] srt_hi, srt_md, srt_lo;

    logic accept;
    logic take_bypass;

    assign accept = in_valid & in_ready;
`ifdef MEDIAN3X3_BYPASS_EN
    assign take_bypass = accept & bypass;
`else
    assign take_bypass = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_OUT: begin
                if (accept)
                    state_nxt = take_bypass ? S_OUT : S_C0;
                else if (state == S_OUT && out_ready)
                    state_nxt = S_IDLE;
            end
            S_C0:    state_nxt = S_C1;
            S_C1:    state_nxt = S_C2;
            S_C2:    state_nxt = S_R0;
            S_R0:    state_nxt = S_R1;
            S_R1:    state_nxt = S_R2;
            S_R2:    state_nxt = S_FIN;
            S_FIN:   state_nxt = S_OUT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs and the sorter operand mux
    always_comb begin
        in_ready = (state == S_IDLE) | ((state == S_OUT) & out_ready);
        busy     = (state != S_IDLE);
        srt_a    = '0;
        srt_b    = '0;
        srt_c    = '0;
        unique case (state)
            S_C0:  begin srt_a = win_r[0]; srt_b = win_r[3]; srt_c = win_r[6]; end
            S_C1:  begin srt_a = win_r[1]; srt_b = win_r[4]; srt_c = win_r[7]; end
            S_C2:  begin srt_a = win_r[2]; srt_b = win_r[5]; srt_c = win_r[8]; end
            S_R0:  begin srt_a = lo_r[0];  srt_b = lo_r[1];  srt_c = lo_r[2];  end
            S_R1:  begin srt_a = md_r[0];  srt_b = md_r[1];  srt_c = md_r[2];  end
            S_R2:  begin srt_a = hi_r[0];  srt_b = hi_r[1];  srt_c = hi_r[2];  end
            S_FIN: begin srt_a = a_r;      srt_b = b_r;      srt_c = c_r;      end
            default: ;
        endcase
    end

    sort_3 #(.WIDTH(WIDTH)) u_sort (
        .a  (srt_a),
        .b  (srt_b),
        .c  (srt_c),
        .hi (srt_hi),
        .md (srt_md),
        .lo (srt_lo)
    );

    // Datapath: window capture, per-pass result capture, output register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPIX; k++) win_r[k] <= '0;
            for (int k = 0; k < NCOL; k++) begin
                hi_r[k] <= '0;
                md_r[k] <= '0;
                lo_r[k] <= '0;
            end
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            out_med   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < NPIX; k++) win_r[k] <= in_win[k*WIDTH +: WIDTH];
            end
            unique case (state)
                S_C0: begin hi_r[0] <= srt_hi; md_r[0] <= srt_md; lo_r[0] <= srt_lo; end
                S_C1: begin hi_r[1] <= srt_hi; md_r[1] <= srt_md; lo_r[1] <= srt_lo; end
                S_C2: begin hi_r[2] <= srt_hi; md_r[2] <= srt_md; lo_r[2] <= srt_lo; end
                S_R0: a_r <= srt_hi;
                S_R1: b_r <= srt_md;
                S_R2: c_r <= srt_lo;
                default: ;
            endcase
            if (state == S_FIN) begin
                out_med   <= srt_md;
                out_valid <= 1'b1;
            end else if (state == S_OUT && out_ready) begin
                out_valid <= 1'b0;
            end
            // Centre pixel goes straight to the output, skipping the passes
            if (take_bypass) begin
                out_med   <= in_win[4*WIDTH +: WIDTH];
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// Three-input unsigned sorter; strict compares so equal values order arbitrarily but correctly.
module sort_3 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] md,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] x, y;

    always_comb begin
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        hi = x;
        md = c;
        lo = y;
        if (c > x) begin
            hi = c;
            md = x;
        end else if (y > c) begin
            md = y;
            lo = c;
        end
    end

endmodule
